crossbar_route_planner: RTL and testbench
=========================================

Name: crossbar_route_planner

Overview:
- Sequential control generator sitting directly upstream of the 4x4 4-bit crossbar. It drives the crossbar's 5-bit control bus.
- Accepts a requested output-to-input mapping and searches the 32 switch settings, one per cycle, for the lowest setting that realises the mapping.
- Registers the winning setting onto ctrl_out and reports success or failure through a valid/ready response.

Parameters:
- SEARCH_LIMIT, 32: number of candidate settings tried, 1..32. Candidates are 0..SEARCH_LIMIT-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  planner can accept a request (high only in IDLE)
- sel_out1  input  2  input index (0=in1..3=in4) required at out1
- sel_out2  input  2  input index required at out2
- sel_out3  input  2  input index required at out3
- sel_out4  input  2  input index required at out4
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_err  output  1  1 = request not a permutation, or no setting found
- ctrl_out  output  5  crossbar control bus, registered

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. rsp_valid=0, rsp_err=0, ctrl_out=5'b00000 (identity routing). State=IDLE, candidate counter=0.
- Reset mid-search or mid-response aborts everything. Outputs return to reset values the next cycle and the request is discarded.
- Switch model, used for the per-cycle match test. Each 2x2 element passes (out1=in1, out2=in2) when its bit is 0 and swaps when its bit is 1.
  - c0 takes (in1, in2) under bit0, producing A1, A2.
  - c3 takes (in3, in4) under bit3, producing B1, B2.
  - c2 takes (A2, B1) under bit2, producing M1, M2.
  - c1 takes (A1, M1) under bit1, producing out1, out2.
  - c4 takes (M2, B2) under bit4, producing out3, out4.
- States:
  - IDLE: req_ready=1. On req_valid (accept cycle T), latch sel_out1..4.
    - If the four indices are not distinct, go to RESP with err=1. rsp_valid=1 at T+1.
    - Otherwise clear the counter and go to SEARCH.
  - SEARCH: each cycle, evaluate candidate k = counter through the switch model and compare it against the latched selections.
    - Match: latch ctrl_out=k, err=0, go to RESP. rsp_valid rises the next cycle, so a match on candidate k gives rsp_valid at T+2+k.
    - No match and k=SEARCH_LIMIT-1: err=1, go to RESP. ctrl_out is unchanged.
    - Otherwise increment the counter. The counter is 5 bits and never wraps; exhaustion ends the search.
  - RESP: rsp_valid=1, holding rsp_err steady. On rsp_ready, rsp_valid drops the next cycle and the state returns to IDLE.
    - A new request can be accepted no earlier than the cycle after the response handshake.
- ctrl_out changes only on a successful match. Failed or rejected requests leave the previous routing in place.
- req_valid is ignored outside IDLE. sel_out* are sampled only at acceptance.
- Worst-case latency from acceptance to rsp_valid: SEARCH_LIMIT+1 cycles (T+33 at default).

Decomposition:
- Shared package holds:
  - CTRL_W=5 and IDX_W=2
  - state enum {IDLE, SEARCH, RESP}
  - index constants IN1..IN4 = 0..3
- One natural combinational sub-module, crossbar_route_model. It maps a 5-bit candidate to four 2-bit source indices, using index tags rather than data.
  - It is instantiated once in the planner.
  - The verification bench reuses it as its reference model.

Test Plan:
- Identity request sel=(0,1,2,3) accepted at T: rsp_valid at T+2, rsp_err=0, ctrl_out=5'b00000.
- Swap in1/in2, sel=(1,0,2,3): candidate 1 matches, rsp_valid at T+3, ctrl_out=5'b00001. The lower candidate 0 is skipped; 5'b00010 also realises this mapping but is not chosen.
- Mapping sel=(2,0,1,3): first match is candidate 6, rsp_valid at T+8, ctrl_out=5'b00110. Drive the crossbar with in1..in4=1,2,3,4 and check outputs 3,1,2,4.
- Non-permutation sel=(0,0,2,3): rsp_valid at T+1, rsp_err=1, ctrl_out keeps its previous value.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid, rsp_err and ctrl_out stay stable, req_ready stays 0, and a req_valid pulse during the stall is ignored.
- Assert rst at SEARCH cycle 3 of a long search: next cycle ctrl_out=0, rsp_valid=0, req_ready=1 after reset release, and no response is issued.

Source files
------------

// File: rtl/crossbar_route_planner_pkg.sv
// Shared widths, FSM encoding and input index tags for the crossbar route planner.
// Pure declarations, no logic.
// Not applicable: no flow control lives here.
package crossbar_route_planner_pkg;

    localparam int CTRL_W = 5;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IN1 = 2'd0;
    localparam logic [IDX_W-1:0] IN2 = 2'd1;
    localparam logic [IDX_W-1:0] IN3 = 2'd2;
    localparam logic [IDX_W-1:0] IN4 = 2'd3;

endpackage

// File: rtl/crossbar_route_model.sv
// Maps a crossbar control word to the input index seen at each output.
// Purely combinational, zero latency.
// No flow control; the result is valid whenever ctrl is.
module crossbar_route_model
    import crossbar_route_planner_pkg::*;
(
    input  logic [CTRL_W-1:0] ctrl,
    output logic [IDX_W-1:0]  src1,
    output logic [IDX_W-1:0]  src2,
    output logic [IDX_W-1:0]  src3,
    output logic [IDX_W-1:0]  src4
);

    logic [IDX_W-1:0] a1, a2, b1, b2, m1, m2;

    // Push index tags through the five 2x2 elements; a set bit swaps that element.
    always_comb begin
        a1   = ctrl[0] ? IN2 : IN1;
        a2   = ctrl[0] ? IN1 : IN2;
        b1   = ctrl[3] ? IN4 : IN3;
        b2   = ctrl[3] ? IN3 : IN4;
        m1   = ctrl[2] ? b1 : a2;
        m2   = ctrl[2] ? a2 : b1;
        src1 = ctrl[1] ? m1 : a1;
        src2 = ctrl[1] ? a1 : m1;
        src3 = ctrl[4] ? b2 : m2;
        src4 = ctrl[4] ? m2 : b2;
    end

endmodule

// File: rtl/crossbar_route_planner.sv
// Searches crossbar settings, lowest first, for one realising the requested output->input map.
// Latency: err response 1 cycle after accept; match on candidate k responds k+2 cycles after accept.
// Backpressure: response is held stable until rsp_ready; req_ready is high only while idle.
module crossbar_route_planner
    import crossbar_route_planner_pkg::*;
#(
    parameter int SEARCH_LIMIT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  sel_out1,
    input  logic [IDX_W-1:0]  sel_out2,
    input  logic [IDX_W-1:0]  sel_out3,
    input  logic [IDX_W-1:0]  sel_out4,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic [CTRL_W-1:0] ctrl_out
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SEARCH = SEARCH;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0]        state;
    logic [CTRL_W-1:0] cand;
    logic [IDX_W-1:0]  want1, want2, want3, want4;
    logic [IDX_W-1:0]  got1, got2, got3, got4;
    logic              distinct;
    logic              match;
    logic              last;

    crossbar_route_model u_model (
        .ctrl (cand),
        .src1 (got1),
        .src2 (got2),
        .src3 (got3),
        .src4 (got4)
    );

    // Request validity, candidate match and exhaustion checks.
    always_comb begin
        distinct = (sel_out1 != sel_out2) && (sel_out1 != sel_out3) &&
                   (sel_out1 != sel_out4) && (sel_out2 != sel_out3) &&
                   (sel_out2 != sel_out4) && (sel_out3 != sel_out4);
        match    = (got1 == want1) && (got2 == want2) &&
                   (got3 == want3) && (got4 == want4);
        last     = (cand == CTRL_W'(SEARCH_LIMIT - 1));
    end

    assign req_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_RESP);

    // Planner FSM: accept, search one candidate per cycle, hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cand     <= '0;
            want1    <= '0;
            want2    <= '0;
            want3    <= '0;
            want4    <= '0;
            rsp_err  <= 1'b0;
            ctrl_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        want1 <= sel_out1;
                        want2 <= sel_out2;
                        want3 <= sel_out3;
                        want4 <= sel_out4;
                        if (!distinct) begin
                            rsp_err <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            cand  <= '0;
                            state <= S_SEARCH;
                        end
                    end
                end
                S_SEARCH: begin
                    if (match) begin
                        ctrl_out <= cand;
                        rsp_err  <= 1'b0;
                        state    <= S_RESP;
                    end else if (last) begin
                        // Exhausted: keep the previous routing in place.
                        rsp_err <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cand <= cand + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crossbar_route_planner.sv
// Directed bench for crossbar_route_planner: table of requests plus stall and reset sequences.
// Response latency is measured in clock edges from the accept edge.
// Consumer backpressure is exercised explicitly in one sequence.
module tb_crossbar_route_planner;
    import crossbar_route_planner_pkg::*;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  sel_out1, sel_out2, sel_out3, sel_out4;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [CTRL_W-1:0] ctrl_out;

    logic [IDX_W-1:0]  m1, m2, m3, m4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] s1, s2, s3, s4;
        logic       exp_err;
        logic [4:0] exp_ctrl;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    crossbar_route_planner dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .sel_out1  (sel_out1),
        .sel_out2  (sel_out2),
        .sel_out3  (sel_out3),
        .sel_out4  (sel_out4),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_err   (rsp_err),
        .ctrl_out  (ctrl_out)
    );

    // Reference crossbar: shows which input reaches each output for the current ctrl_out.
    crossbar_route_model u_ref (
        .ctrl (ctrl_out),
        .src1 (m1),
        .src2 (m2),
        .src3 (m3),
        .src4 (m4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a request for one cycle; returns #1 after the accept edge.
    task automatic send(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
        chk("req_ready_before_send", int'(req_ready), 1);
        sel_out1  = a;
        sel_out2  = b;
        sel_out3  = c;
        sel_out4  = d;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges from the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 64 cycles");
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after_handshake", int'(rsp_valid), 0);
        chk("req_ready_after_handshake", int'(req_ready), 1);
    endtask

    logic [2:0] din[4];

    initial begin
        int lat;

        // in1..in4 carry data 1..4 so an output's data is its source index + 1.
        din[0] = 3'd1; din[1] = 3'd2; din[2] = 3'd3; din[3] = 3'd4;

        vecs[0] = '{2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 5'd0, 2};
        vecs[1] = '{2'd1, 2'd0, 2'd2, 2'd3, 1'b0, 5'd1, 3};
        vecs[2] = '{2'd0, 2'd0, 2'd2, 2'd3, 1'b1, 5'd1, 1};
        vecs[3] = '{2'd2, 2'd0, 2'd1, 2'd3, 1'b0, 5'd6, 8};
        vecs[4] = '{2'd1, 2'd2, 2'd0, 2'd3, 1'b0, 5'd5, 7};
        vecs[5] = '{2'd3, 2'd3, 2'd3, 2'd3, 1'b1, 5'd5, 1};
        vecs[6] = '{2'd0, 2'd1, 2'd3, 2'd2, 1'b0, 5'd8, 10};

        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        sel_out1  = '0;
        sel_out2  = '0;
        sel_out3  = '0;
        sel_out4  = '0;

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_ctrl_out", int'(ctrl_out), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;

        // Table-driven requests.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4);
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_rsp_err", i), int'(rsp_err), int'(vecs[i].exp_err));
            chk($sformatf("v%0d_ctrl_out", i), int'(ctrl_out), int'(vecs[i].exp_ctrl));
            if (!vecs[i].exp_err) begin
                chk($sformatf("v%0d_data_out1", i), int'(din[m1]), int'(vecs[i].s1) + 1);
                chk($sformatf("v%0d_data_out2", i), int'(din[m2]), int'(vecs[i].s2) + 1);
                chk($sformatf("v%0d_data_out3", i), int'(din[m3]), int'(vecs[i].s3) + 1);
                chk($sformatf("v%0d_data_out4", i), int'(din[m4]), int'(vecs[i].s4) + 1);
            end
            handshake();
        end

        // Backpressure: response held for 5 stalled cycles, stray request ignored.
        send(2'd1, 2'd0, 2'd2, 2'd3);
        wait_rsp(lat);
        chk("bp_latency", lat, 3);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                sel_out1  = 2'd0;
                sel_out2  = 2'd0;
                sel_out3  = 2'd0;
                sel_out4  = 2'd0;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_err", int'(rsp_err), 0);
            chk("bp_ctrl_out", int'(ctrl_out), 1);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        req_valid = 1'b0;
        handshake();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_no_stray_rsp", int'(rsp_valid), 0);
        end
        chk("bp_ctrl_kept", int'(ctrl_out), 1);

        // Reset while evaluating candidate 3 of a search that would end at candidate 8.
        send(2'd0, 2'd1, 2'd3, 2'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_search_no_rsp", int'(rsp_valid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ctrl_out", int'(ctrl_out), 0);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_rsp_err", int'(rsp_err), 0);
        chk("abort_req_ready_in_reset", int'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("abort_req_ready_after", int'(req_ready), 1);
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        chk("abort_ctrl_stays", int'(ctrl_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
